// File: rtl/smart_attest_seq_pkg.sv
// Shared types and default parameters for the SMART attestation read sequencer.
package smart_attest_seq_pkg;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StIssue = 3'd1,
    StCapt  = 3'd2,
    StHold  = 3'd3,
    StFin   = 3'd4
  } state_e;

  // Default memory word-address MSB index and key-store bounds (inclusive)
  localparam int unsigned DefSizeMemAddr = 15;
  localparam int unsigned DefLowKey      = 200;
  localparam int unsigned DefHighKey     = 200;

endpackage

// File: rtl/smart_attest_seq_range_chk.sv
// Combinational order / key-store overlap check of an inclusive word range.
// Kept standalone so the MAC block can reuse the same protection rule.
module smart_attest_seq_range_chk #(
  parameter int unsigned AW       = 16,
  parameter int unsigned LOW_KEY  = 200,
  parameter int unsigned HIGH_KEY = 200
) (
  input  logic [AW-1:0] start_addr_i,
  input  logic [AW-1:0] end_addr_i,
  output logic          order_err_o,
  output logic          key_hit_o,
  output logic          range_bad_o
);

  localparam logic [AW-1:0] LowKeyA  = AW'(LOW_KEY);
  localparam logic [AW-1:0] HighKeyA = AW'(HIGH_KEY);

  // Reversed range, or any word of the range inside the key store
  always_comb begin
    order_err_o = start_addr_i > end_addr_i;
    key_hit_o   = (start_addr_i <= HighKeyA) && (end_addr_i >= LowKeyA);
    range_bad_o = order_err_o | key_hit_o;
  end

endmodule

// File: rtl/smart_attest_seq.sv
// Attestation read sequencer: streams a word range from data memory to the hash
// core over valid/ready, stealing only memory cycles the CPU leaves idle.
module smart_attest_seq
  import smart_attest_seq_pkg::*;
#(
  parameter int unsigned SIZE_MEM_ADDR = DefSizeMemAddr,
  parameter int unsigned LOW_KEY       = DefLowKey,
  parameter int unsigned HIGH_KEY      = DefHighKey
) (
  input  logic                   mclk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [SIZE_MEM_ADDR:0] start_addr_i,
  input  logic [SIZE_MEM_ADDR:0] end_addr_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  input  logic                   cpu_cen_i,
  input  logic [SIZE_MEM_ADDR:0] cpu_addr_i,
  output logic                   mem_cen_o,
  output logic [SIZE_MEM_ADDR:0] mem_addr_o,
  input  logic [15:0]            mem_rdata_i,
  output logic [15:0]            data_out_o,
  output logic                   data_valid_o,
  input  logic                   data_ready_i
);

  localparam int unsigned AW = SIZE_MEM_ADDR + 1;

  state_e        state_q, state_d;
  logic [AW-1:0] cur_q, cur_d;
  logic [AW-1:0] end_q, end_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          valid_q, valid_d;
  logic [15:0]   dout_q, dout_d;
  logic          seq_rd;
  logic          order_err, key_hit, range_bad;

  smart_attest_seq_range_chk #(
    .AW       (AW),
    .LOW_KEY  (LOW_KEY),
    .HIGH_KEY (HIGH_KEY)
  ) u_range_chk (
    .start_addr_i (start_addr_i),
    .end_addr_i   (end_addr_i),
    .order_err_o  (order_err),
    .key_hit_o    (key_hit),
    .range_bad_o  (range_bad)
  );

  // Next-state and datapath update; abort overrides everything in active states
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    end_d   = end_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    valid_d = valid_q;
    dout_d  = dout_q;
    seq_rd  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          err_d = 1'b0;
          if (range_bad) begin
            err_d   = 1'b1;
            state_d = StFin;
          end else begin
            cur_d   = start_addr_i;
            end_d   = end_addr_i;
            busy_d  = 1'b1;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        // CPU owns the port whenever it is enabling memory
        seq_rd = cpu_cen_i;
        if (cpu_cen_i) state_d = StCapt;
      end
      StCapt: begin
        dout_d  = mem_rdata_i;
        valid_d = 1'b1;
        last_d  = (cur_q == end_q);
        cur_d   = cur_q + 1'b1;
        state_d = StHold;
      end
      StHold: begin
        if (data_ready_i) begin
          valid_d = 1'b0;
          state_d = last_q ? StFin : StIssue;
        end
      end
      StFin: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // In-flight read data is dropped on abort
    if (abort_i && (state_q inside {StIssue, StCapt, StHold})) begin
      cur_d   = cur_q;
      last_d  = last_q;
      dout_d  = dout_q;
      valid_d = 1'b0;
      err_d   = 1'b1;
      state_d = StFin;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge mclk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cur_q   <= '0;
      end_q   <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      end_q   <= end_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      dout_q  <= dout_d;
    end
  end

  // Memory port mux: CPU passes through untouched unless the sequencer reads
  always_comb begin
    mem_cen_o    = cpu_cen_i & ~seq_rd;
    mem_addr_o   = seq_rd ? cur_q : cpu_addr_i;
    busy_o       = busy_q;
    done_o       = done_q;
    error_o      = err_q;
    data_valid_o = valid_q;
    data_out_o   = dout_q;
  end

endmodule

// File: tb/tb_smart_attest_seq.sv
// Self-checking bench for smart_attest_seq: a per-cycle vector table for a basic
// run plus directed sequences for CPU contention, back-pressure, key protection,
// abort and reset.
module tb_smart_attest_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] start_addr = '0;
  logic [15:0] end_addr = '0;
  logic        busy, done, error;
  logic        cpu_cen = 1'b1;
  logic [15:0] cpu_addr = 16'h0555;
  logic        mem_cen;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata = '0;
  logic [15:0] data_out;
  logic        data_valid;
  logic        data_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  smart_attest_seq #(
    .SIZE_MEM_ADDR (15),
    .LOW_KEY       (200),
    .HIGH_KEY      (210)
  ) dut (
    .mclk_i       (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .abort_i      (abort),
    .start_addr_i (start_addr),
    .end_addr_i   (end_addr),
    .busy_o       (busy),
    .done_o       (done),
    .error_o      (error),
    .cpu_cen_i    (cpu_cen),
    .cpu_addr_i   (cpu_addr),
    .mem_cen_o    (mem_cen),
    .mem_addr_o   (mem_addr),
    .mem_rdata_i  (mem_rdata),
    .data_out_o   (data_out),
    .data_valid_o (data_valid),
    .data_ready_i (data_ready)
  );

  always #5 clk = ~clk;

  // Synchronous memory: word content is 0xA000 ^ address
  always @(posedge clk) if (!mem_cen) mem_rdata <= 16'hA000 ^ mem_addr;

  typedef struct {
    logic        start, cen, rdy;
    logic        busy, done, err, valid, mcen;
    logic [15:0] maddr, dout;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic [15:0] a0, input logic [15:0] a1);
    start_addr = a0;
    end_addr   = a1;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // Drive a run to completion with free memory and sink; check every word and read address
  task automatic run_words(input logic [15:0] a0, input logic [15:0] a1, input int n0);
    int n = n0;
    int cyc = 0;
    bit got_done = 1'b0;
    cpu_cen    = 1'b1;
    data_ready = 1'b1;
    #1;
    while (!got_done && cyc < 300) begin
      if (!mem_cen) chk("seq_addr", mem_addr, a0 + 16'(n));
      if (data_valid) begin
        chk("word", data_out, 16'hA000 ^ (a0 + 16'(n)));
        n++;
      end
      if (done) got_done = 1'b1;
      else tick();
      cyc++;
    end
    chk("run_done_seen", got_done, 1'b1);
    chk("run_word_count", n, 32'(a1 - a0) + 1);
    chk("run_error", error, 1'b0);
    chk("run_busy_end", busy, 1'b0);
  endtask

  task automatic wait_valid(input string name);
    int cyc = 0;
    while (!data_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    chk(name, data_valid, 1'b1);
  endtask

  initial begin
    // Test 1 table: 0x0100..0x0103, CPU idle, sink always ready
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0555, 16'h0000};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0000};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0555, 16'h0000};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0555, 16'hA100};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0101, 16'hA100};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0555, 16'hA100};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0555, 16'hA101};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0102, 16'hA101};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0555, 16'hA101};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0555, 16'hA102};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0103, 16'hA102};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0555, 16'hA102};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0555, 16'hA103};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0555, 16'hA103};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0555, 16'hA103};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0555, 16'hA103};

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_dout", data_out, 16'h0000);
    chk("rst_mem_cen", mem_cen, 1'b1);
    chk("rst_mem_addr", mem_addr, 16'h0555);

    // Test 1
    start_addr = 16'h0100;
    end_addr   = 16'h0103;
    for (int i = 0; i < 16; i++) begin
      start      = vecs[i].start;
      cpu_cen    = vecs[i].cen;
      data_ready = vecs[i].rdy;
      #1;
      chk($sformatf("t1_busy[%0d]", i), busy, vecs[i].busy);
      chk($sformatf("t1_done[%0d]", i), done, vecs[i].done);
      chk($sformatf("t1_err[%0d]", i), error, vecs[i].err);
      chk($sformatf("t1_valid[%0d]", i), data_valid, vecs[i].valid);
      chk($sformatf("t1_mcen[%0d]", i), mem_cen, vecs[i].mcen);
      chk($sformatf("t1_maddr[%0d]", i), mem_addr, vecs[i].maddr);
      chk($sformatf("t1_dout[%0d]", i), data_out, vecs[i].dout);
      tick();
    end

    // Test 2: CPU holds the port for 5 cycles while sequencer waits in ISSUE
    cpu_cen  = 1'b0;
    cpu_addr = 16'h0777;
    start_cmd(16'h0100, 16'h0101);
    for (int i = 0; i < 5; i++) begin
      chk("t2_cpu_cen", mem_cen, 1'b0);
      chk("t2_cpu_addr", mem_addr, 16'h0777);
      chk("t2_busy", busy, 1'b1);
      tick();
    end
    cpu_cen = 1'b1;
    #1;
    chk("t2_first_rd_cen", mem_cen, 1'b0);
    chk("t2_first_rd_addr", mem_addr, 16'h0100);
    run_words(16'h0100, 16'h0101, 0);
    tick();

    // Test 3: back-pressure holds data and blocks the next read
    data_ready = 1'b0;
    start_cmd(16'h0100, 16'h0101);
    wait_valid("t3_valid_seen");
    for (int i = 0; i < 4; i++) begin
      chk("t3_hold_valid", data_valid, 1'b1);
      chk("t3_hold_data", data_out, 16'hA100);
      chk("t3_no_seq_rd", mem_cen, 1'b1);
      tick();
    end
    data_ready = 1'b1;
    tick();
    chk("t3_next_rd_cen", mem_cen, 1'b0);
    chk("t3_next_rd_addr", mem_addr, 16'h0101);
    chk("t3_valid_drop", data_valid, 1'b0);
    run_words(16'h0100, 16'h0101, 1);
    tick();

    // Test 4: key-store overlap and reversed range are rejected without memory access
    for (int k = 0; k < 2; k++) begin
      logic [15:0] a0, a1;
      a0 = (k == 0) ? 16'd190 : 16'd300;
      a1 = (k == 0) ? 16'd200 : 16'd290;
      cpu_cen = 1'b1;
      chk("t4_idle_mcen", mem_cen, 1'b1);
      start_cmd(a0, a1);
      chk("t4_fin_err", error, 1'b1);
      chk("t4_fin_busy", busy, 1'b0);
      chk("t4_fin_done", done, 1'b0);
      chk("t4_fin_mcen", mem_cen, 1'b1);
      tick();
      chk("t4_done", done, 1'b1);
      chk("t4_done_err", error, 1'b1);
      chk("t4_done_mcen", mem_cen, 1'b1);
      tick();
      chk("t4_done_pulse", done, 1'b0);
    end
    start_cmd(16'd211, 16'd220);
    chk("t4_err_cleared", error, 1'b0);
    chk("t4_busy", busy, 1'b1);
    run_words(16'd211, 16'd220, 0);
    tick();

    // Test 5: abort while word 2 is held
    begin
      int n = 0;
      int cyc = 0;
      data_ready = 1'b1;
      start_cmd(16'h0100, 16'h0107);
      while (n < 2 && cyc < 100) begin
        if (data_valid) n++;
        if (n < 2) tick();
        cyc++;
      end
      chk("t5_word2_reached", n, 2);
      chk("t5_word2_data", data_out, 16'hA101);
      abort      = 1'b1;
      data_ready = 1'b0;
      tick();
      abort = 1'b0;
      chk("t5_valid_drop", data_valid, 1'b0);
      chk("t5_error", error, 1'b1);
      chk("t5_no_early_done", done, 1'b0);
      tick();
      chk("t5_done", done, 1'b1);
      chk("t5_busy_clr", busy, 1'b0);
      tick();
      chk("t5_done_pulse", done, 1'b0);
      chk("t5_error_sticky", error, 1'b1);
      start_cmd(16'h0100, 16'h0101);
      chk("t5_restart_err", error, 1'b0);
      chk("t5_restart_busy", busy, 1'b1);
      run_words(16'h0100, 16'h0101, 0);
      tick();
    end

    // Test 6: synchronous reset mid-run
    start_cmd(16'h0100, 16'h0107);
    wait_valid("t6_valid_seen");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_busy", busy, 1'b0);
    chk("t6_done", done, 1'b0);
    chk("t6_error", error, 1'b0);
    chk("t6_valid", data_valid, 1'b0);
    chk("t6_dout", data_out, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      cpu_cen  = i[0];
      cpu_addr = 16'h0300 + 16'(i);
      #1;
      chk("t6_mcen_pass", mem_cen, cpu_cen);
      chk("t6_maddr_pass", mem_addr, 16'h0300 + 16'(i));
      chk("t6_no_done", done, 1'b0);
      tick();
    end

    // Start and abort together in IDLE: start wins; single-word range
    cpu_cen = 1'b1;
    abort   = 1'b1;
    start_cmd(16'h0120, 16'h0120);
    abort = 1'b0;
    chk("t7_busy", busy, 1'b1);
    chk("t7_error", error, 1'b0);
    run_words(16'h0120, 16'h0120, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
